// File: rtl/cnt_seq_ctrl.sv
// Bounded count sequencer: walks a counter from a start value to an end value,
// up or down, for a programmed number of passes, with hold/abort/error reporting.
module cnt_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic [WIDTH-1:0] cfg_start,
   input  logic [WIDTH-1:0] cfg_end,
   input  logic             cfg_dir,
   input  logic [REP_W-1:0] cfg_reps,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             wrap,
   output logic             done,
   output logic             abort,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
   localparam logic [REP_W-1:0] PASS_ONE = REP_W'(1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] cnt, cnt_nx;
   logic [REP_W-1:0] pass_cnt, pass_nx;
   logic             wrap_nx, abort_nx, err_nx, load;
   logic             cfg_ok;

   // Shadow copies: the run only ever looks at these, never at live cfg_*
   logic [WIDTH-1:0] start_s, end_s;
   logic             dir_s;
   logic [REP_W-1:0] reps_s;

   assign cfg_ok = cfg_dir ? (cfg_end <= cfg_start) : (cfg_end >= cfg_start);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pass_nx  = pass_cnt;
      wrap_nx  = 1'b0;
      abort_nx = 1'b0;
      err_nx   = 1'b0;
      load     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  load     = 1'b1;
                  cnt_nx   = cfg_start;
                  pass_nx  = '0;
                  state_nx = RUN;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         RUN: begin
            // Priority: stop, then hold, then end-of-pass, then step.
            if (stop) begin
               abort_nx = 1'b1;
               state_nx = IDLE;
            end else if (hold) begin
               cnt_nx = cnt;
            end else if (cnt == end_s) begin
               if (pass_cnt == reps_s) begin
                  state_nx = DONE;
               end else begin
                  cnt_nx  = start_s;
                  pass_nx = pass_cnt + PASS_ONE;
                  wrap_nx = 1'b1;
               end
            end else begin
               cnt_nx = dir_s ? (cnt - CNT_ONE) : (cnt + CNT_ONE);
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pass_cnt <= '0;
         wrap     <= 1'b0;
         abort    <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         pass_cnt <= pass_nx;
         wrap     <= wrap_nx;
         abort    <= abort_nx;
         err      <= err_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         start_s <= cfg_start;
         end_s   <= cfg_end;
         dir_s   <= cfg_dir;
         reps_s  <= cfg_reps;
      end
   end

   // busy/done decode straight from the state register, so they stay registered
   assign out  = cnt;
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: each scenario task drives stimulus and
// compares outputs against hand-computed sequences.
module tb_cnt_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, stop, hold, cfg_dir;
   logic [3:0] cfg_start, cfg_end, cfg_reps;
   logic [3:0] out;
   logic       busy, wrap, done, abort, err;

   int compared   = 0;
   int mismatched = 0;

   cnt_seq_ctrl #(.WIDTH(4), .REP_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
      .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_dir(cfg_dir), .cfg_reps(cfg_reps),
      .out(out), .busy(busy), .wrap(wrap), .done(done), .abort(abort), .err(err)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] s, input logic [3:0] e,
                           input logic d, input logic [3:0] r);
      cfg_start = s; cfg_end = e; cfg_dir = d; cfg_reps = r;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; stop = 0; hold = 0;
      cfg_start = 0; cfg_end = 0; cfg_dir = 0; cfg_reps = 0;
      tick(); tick();
      rst = 1'b0;
      compared++; if (out !== 4'd0) begin $display("FAIL reset_out got %0d want 0", out); mismatched++; end
      compared++; if ({busy, wrap, done, abort, err} !== 5'b0) begin
         $display("FAIL reset_flags got %b want 00000", {busy, wrap, done, abort, err}); mismatched++; end
      tick();
      compared++; if ({busy, done} !== 2'b0) begin $display("FAIL idle_flags got %b want 00", {busy, done}); mismatched++; end
   endtask

   task automatic test_up_reps();
      logic [3:0] seq [8] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd3, 4'd4, 4'd5, 4'd6};
      do_start(4'd3, 4'd6, 1'b0, 4'd1);
      for (int i = 0; i < 8; i++) begin
         compared++; if (out !== seq[i] || busy !== 1'b1) begin
            $display("FAIL up_seq[%0d] got out=%0d busy=%b want out=%0d busy=1", i, out, busy, seq[i]); mismatched++; end
         compared++; if (wrap !== (i == 4) || done !== 1'b0) begin
            $display("FAIL up_wrap[%0d] got wrap=%b done=%b want wrap=%b done=0", i, wrap, done, i == 4); mismatched++; end
         tick();
      end
      compared++; if (done !== 1'b1 || busy !== 1'b0 || out !== 4'd6) begin
         $display("FAIL up_done got done=%b busy=%b out=%0d want 1 0 6", done, busy, out); mismatched++; end
      tick();
      compared++; if (done !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL up_idle got done=%b busy=%b want 0 0", done, busy); mismatched++; end
   endtask

   task automatic test_down_and_full();
      logic [3:0] seq [3] = '{4'd9, 4'd8, 4'd7};
      do_start(4'd9, 4'd7, 1'b1, 4'd0);
      for (int i = 0; i < 3; i++) begin
         compared++; if (out !== seq[i] || busy !== 1'b1) begin
            $display("FAIL down_seq[%0d] got out=%0d busy=%b want out=%0d busy=1", i, out, busy, seq[i]); mismatched++; end
         tick();
      end
      compared++; if (done !== 1'b1 || out !== 4'd7) begin
         $display("FAIL down_done got done=%b out=%0d want 1 7", done, out); mismatched++; end
      tick();
      do_start(4'd0, 4'd15, 1'b0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         compared++; if (out !== 4'(i) || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL full_seq[%0d] got out=%0d busy=%b done=%b want out=%0d busy=1 done=0", i, out, busy, done, i); mismatched++; end
         tick();
      end
      compared++; if (done !== 1'b1 || busy !== 1'b0 || out !== 4'd15) begin
         $display("FAIL full_done got done=%b busy=%b out=%0d want 1 0 15", done, busy, out); mismatched++; end
      tick();
   endtask

   task automatic test_invalid();
      logic [3:0] seq [4] = '{4'd5, 4'd4, 4'd3, 4'd2};
      do_start(4'd5, 4'd2, 1'b0, 4'd0);
      compared++; if (err !== 1'b1 || busy !== 1'b0 || out !== 4'd15) begin
         $display("FAIL invalid_err got err=%b busy=%b out=%0d want 1 0 15", err, busy, out); mismatched++; end
      tick();
      compared++; if (err !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL invalid_pulse got err=%b busy=%b want 0 0", err, busy); mismatched++; end
      do_start(4'd5, 4'd2, 1'b1, 4'd0);
      for (int i = 0; i < 4; i++) begin
         compared++; if (out !== seq[i] || busy !== 1'b1 || err !== 1'b0) begin
            $display("FAIL valid_down[%0d] got out=%0d busy=%b err=%b want out=%0d busy=1 err=0", i, out, busy, err, seq[i]); mismatched++; end
         tick();
      end
      compared++; if (done !== 1'b1 || out !== 4'd2) begin
         $display("FAIL valid_down_done got done=%b out=%0d want 1 2", done, out); mismatched++; end
      tick();
   endtask

   task automatic test_hold_stop();
      do_start(4'd0, 4'd7, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) tick();
      compared++; if (out !== 4'd4) begin $display("FAIL hs_pre got out=%0d want 4", out); mismatched++; end
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         compared++; if (out !== 4'd4 || busy !== 1'b1 || wrap !== 1'b0) begin
            $display("FAIL hs_hold[%0d] got out=%0d busy=%b wrap=%b want 4 1 0", i, out, busy, wrap); mismatched++; end
      end
      hold = 1'b0;
      tick();
      compared++; if (out !== 4'd5) begin $display("FAIL hs_resume got out=%0d want 5", out); mismatched++; end
      tick();
      compared++; if (out !== 4'd6) begin $display("FAIL hs_six got out=%0d want 6", out); mismatched++; end
      stop = 1'b1; hold = 1'b1;
      tick();
      stop = 1'b0; hold = 1'b0;
      compared++; if (abort !== 1'b1 || busy !== 1'b0 || out !== 4'd6 || done !== 1'b0) begin
         $display("FAIL hs_abort got abort=%b busy=%b out=%0d done=%b want 1 0 6 0", abort, busy, out, done); mismatched++; end
      tick();
      compared++; if (abort !== 1'b0 || done !== 1'b0 || out !== 4'd6) begin
         $display("FAIL hs_after got abort=%b done=%b out=%0d want 0 0 6", abort, done, out); mismatched++; end
   endtask

   task automatic test_back_to_back();
      do_start(4'd10, 4'd10, 1'b0, 4'd2);
      // Live cfg and start changed during the run; both must be ignored.
      start = 1'b1; cfg_start = 4'd1; cfg_end = 4'd2; cfg_reps = 4'd0;
      for (int i = 0; i < 3; i++) begin
         compared++; if (out !== 4'd10 || busy !== 1'b1 || wrap !== (i != 0)) begin
            $display("FAIL same_seq[%0d] got out=%0d busy=%b wrap=%b want 10 1 %b", i, out, busy, wrap, i != 0); mismatched++; end
         tick();
      end
      compared++; if (done !== 1'b1 || busy !== 1'b0 || out !== 4'd10) begin
         $display("FAIL same_done got done=%b busy=%b out=%0d want 1 0 10", done, busy, out); mismatched++; end
      tick();
      start = 1'b0;
      compared++; if (busy !== 1'b0 || done !== 1'b0 || out !== 4'd10) begin
         $display("FAIL same_ignore got busy=%b done=%b out=%0d want 0 0 10", busy, done, out); mismatched++; end
   endtask

   task automatic test_rst_mid();
      logic [3:0] seq [3] = '{4'd2, 4'd3, 4'd4};
      do_start(4'd0, 4'd9, 1'b0, 4'd0);
      for (int i = 0; i < 5; i++) tick();
      compared++; if (out !== 4'd5) begin $display("FAIL rst_pre got out=%0d want 5", out); mismatched++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      compared++; if (out !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || abort !== 1'b0) begin
         $display("FAIL rst_mid got out=%0d busy=%b done=%b abort=%b want 0 0 0 0", out, busy, done, abort); mismatched++; end
      do_start(4'd2, 4'd4, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         compared++; if (out !== seq[i] || busy !== 1'b1 || abort !== 1'b0) begin
            $display("FAIL rst_rerun[%0d] got out=%0d busy=%b abort=%b want %0d 1 0", i, out, busy, abort, seq[i]); mismatched++; end
         tick();
      end
      compared++; if (done !== 1'b1 || out !== 4'd4) begin
         $display("FAIL rst_rerun_done got done=%b out=%0d want 1 4", done, out); mismatched++; end
      tick();
   endtask

   initial begin
      test_reset();
      test_up_reps();
      test_down_and_full();
      test_invalid();
      test_hold_stop();
      test_back_to_back();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
